// File: rtl/rx232_pkg.sv
// Shared RS-232 receive definitions: frame FSM states and default data width.
package rx232_pkg;

    localparam int unsigned RX232_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx232_state_t;

endpackage

// File: rtl/rx232_samp_det.sv
// Registers the recovered sample clock and emits a one-cycle pulse on its rising edge.
module rx232_samp_det (
    input  logic clk,
    input  logic rst,
    input  logic rxck,
    output logic samp_c
);

    logic rxck_d;

    // Resets high so a level already high at release is not mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxck_d <= 1'b1;
        end else begin
            rxck_d <= rxck;
        end
    end

    assign samp_c = rxck & ~rxck_d;

endmodule

// File: rtl/rx232_deser.sv
// RS-232 frame deserializer with one-entry holding register and valid/ack handshake.
// Optional parity stage and rx_perr flag enabled by defining RX232_PARITY_EN.
module rx232_deser
    import rx232_pkg::*;
#(
    parameter int unsigned DATA_BITS  = RX232_DATA_BITS,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxck,
    input  logic                 rxsdo,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 rx_ovr
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);
`ifdef RX232_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic                 samp_c;
    rx232_state_t         state_q, state_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, ferr_d, perr_d, ovr_d;
    logic                 done_c;

    rx232_samp_det u_samp_det (
        .clk    (clk),
        .rst    (rst),
        .rxck   (rxck),
        .samp_c (samp_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            rx_data  <= data_d;
            rx_valid <= valid_d;
            rx_ferr  <= ferr_d;
            rx_perr  <= perr_d;
            rx_ovr   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = rx_data;
        valid_d  = rx_valid;
        ferr_d   = rx_ferr;
        perr_d   = rx_perr;
        ovr_d    = rx_ovr;
        done_c   = 1'b0;

        // Frame sequencing advances only on recovered sample edges.
        if (samp_c) begin
            case (state_q)
                IDLE: begin
                    if (!rxsdo) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {rxsdo, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = rxsdo;
                    state_d = STOP;
                end
                STOP: begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Holding register: a same-cycle ack frees the slot for the completing frame.
        if (done_c) begin
            if (!rx_valid || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = ~rxsdo;
                perr_d  = PAR_EN & ((^{shift_q, par_q}) ^ PARITY_ODD);
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_rx232_deser.sv
// Self-checking bench for rx232_deser: reset, directed table, corner sequences, random frames.
module tb_rx232_deser;

`ifdef RX232_PARITY_EN
    localparam logic TB_PAR_EN = 1'b1;
`else
    localparam logic TB_PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxck;
    logic       rxsdo;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_perr;
    logic       rx_ovr;

    int checks = 0;
    int failures = 0;

    // Reference model of the holding register
    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_perr, m_ovr;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack_stop;
        logic       ack_after;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_ferr;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [9];

    rx232_deser #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxck     (rxck),
        .rxsdo    (rxsdo),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_perr  (rx_perr),
        .rx_ovr   (rx_ovr)
    );

    always #5 clk = ~clk;

    task automatic cmp1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic par);
        return TB_PAR_EN & (^{d, par});
    endfunction

    task automatic mdl_reset();
        m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic mdl_complete(input logic [7:0] d, input logic par, input logic stop,
                                input logic ack);
        if (!m_valid || ack) begin
            m_data  = d;
            m_valid = 1'b1;
            m_ferr  = ~stop;
            m_perr  = exp_perr(d, par);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic mdl_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        cmp8({tag, "_data"}, rx_data, m_data);
        cmp1({tag, "_valid"}, rx_valid, m_valid);
        cmp1({tag, "_ferr"}, rx_ferr, m_ferr);
        cmp1({tag, "_perr"}, rx_perr, m_perr);
        cmp1({tag, "_ovr"}, rx_ovr, m_ovr);
    endtask

    // One sample: rxck high for one clk, ack optionally coincident with the sample edge.
    task automatic send_bit(input logic b, input logic ack);
        @(negedge clk);
        rxsdo  = b;
        rxck   = 1'b1;
        rx_ack = ack;
        @(negedge clk);
        rxck   = 1'b0;
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        if (TB_PAR_EN) send_bit(par, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic ack_stop);
        send_head(d, par);
        send_bit(stop, ack_stop);
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h22, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h44, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'h99, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; rxck = 1'b0; rxsdo = 1'b1; rx_ack = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        cmp8("reset_data", rx_data, 8'h00);
        cmp1("reset_valid", rx_valid, 1'b0);
        cmp1("reset_ferr", rx_ferr, 1'b0);
        cmp1("reset_perr", rx_perr, 1'b0);
        cmp1("reset_ovr", rx_ovr, 1'b0);
        rst = 1'b0;

        // Idle line produces nothing
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        cmp1("idle_valid", rx_valid, 1'b0);

        // First frame: valid must appear exactly one clk after the stop sample edge
        send_head(8'h5A, ^8'h5A);
        @(negedge clk);
        rxsdo = 1'b1;
        rxck  = 1'b1;
        #1;
        cmp1("lat_before_valid", rx_valid, 1'b0);
        @(negedge clk);
        rxck = 1'b0;
        cmp1("lat_after_valid", rx_valid, 1'b1);
        cmp8("lat_after_data", rx_data, 8'h5A);
        cmp1("lat_after_ferr", rx_ferr, 1'b0);
        @(negedge clk);
        mdl_complete(8'h5A, ^8'h5A, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        cmp1("hold_valid", rx_valid, 1'b1);
        do_ack();
        mdl_ack();
        cmp1("ack_valid", rx_valid, 1'b0);
        cmp8("ack_data_hold", rx_data, 8'h5A);

        // Directed table with hand-derived expectations
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].d, ^vecs[v].d, vecs[v].stop, vecs[v].ack_stop);
            mdl_complete(vecs[v].d, ^vecs[v].d, vecs[v].stop, vecs[v].ack_stop);
            cmp8($sformatf("vec%0d_data", v), rx_data, vecs[v].e_data);
            cmp1($sformatf("vec%0d_valid", v), rx_valid, vecs[v].e_valid);
            cmp1($sformatf("vec%0d_ferr", v), rx_ferr, vecs[v].e_ferr);
            cmp1($sformatf("vec%0d_perr", v), rx_perr, 1'b0);
            cmp1($sformatf("vec%0d_ovr", v), rx_ovr, vecs[v].e_ovr);
            if (vecs[v].ack_after) begin
                do_ack();
                mdl_ack();
                cmp1($sformatf("vec%0d_ack_valid", v), rx_valid, 1'b0);
                cmp1($sformatf("vec%0d_ack_ovr", v), rx_ovr, 1'b0);
                cmp8($sformatf("vec%0d_ack_data", v), rx_data, vecs[v].e_data);
            end
        end

        // Reset during data bit 4 of 0xA5 clears outputs asynchronously
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hA5 >> i), 1'b0);
        @(negedge clk);
        rxsdo = 1'b0;
        rxck  = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_model("midrst");
        cmp8("midrst_data0", rx_data, 8'h00);
        @(negedge clk);
        rxck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hC3, ^8'hC3, 1'b1, 1'b0);
        mdl_complete(8'hC3, ^8'hC3, 1'b1, 1'b0);
        cmp8("post_rst_data", rx_data, 8'hC3);
        cmp1("post_rst_valid", rx_valid, 1'b1);
        do_ack();
        mdl_ack();

`ifdef RX232_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        mdl_complete(8'h07, 1'b1, 1'b1, 1'b0);
        cmp1("par_good_perr", rx_perr, 1'b0);
        do_ack();
        mdl_ack();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        mdl_complete(8'h07, 1'b0, 1'b1, 1'b0);
        cmp1("par_bad_perr", rx_perr, 1'b1);
        do_ack();
        mdl_ack();
`endif

        // Random frames against the behavioural model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            logic       stop, ack_stop, ack_after, par;
            d         = 8'($urandom);
            stop      = ($urandom_range(0, 3) != 0);
            ack_stop  = 1'($urandom_range(0, 1));
            ack_after = ($urandom_range(0, 2) == 0);
            par       = (^d) ^ ($urandom_range(0, 3) == 0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) send_bit(1'b1, 1'b0);
            send_frame(d, par, stop, ack_stop);
            mdl_complete(d, par, stop, ack_stop);
            check_model($sformatf("rnd%0d", n));
            if (ack_after) begin
                do_ack();
                mdl_ack();
                check_model($sformatf("rnd%0d_ack", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
